time_set_controller: RTL

//  Front-panel sequencer for the alarm clock digit counters. Turns debounced buttons into
//  one-hot field selects and single-cycle up/down steps for the time and alarm counters.

---
 rtl/time_set_if.sv | 31 +++
 rtl/time_set_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/time_set_if.sv
// Front-panel bus for the time-set sequencer.
// Purpose: bundles the button/tick inputs and the field-select/strobe outputs
// that pass between the panel side (debouncers, counter chains) and the
// time_set_controller.
//   master : panel side; drives tick and buttons, observes controller outputs
//   slave  : time_set_controller; reads tick and buttons, drives the outputs
interface time_set_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_alarm;
  logic [2:0] mode;
  logic [3:0] field_sel;
  logic       step_up;
  logic       step_down;
  logic       run_en;
  logic       sec_clr;
  logic       blink;
  logic       alarm_armed;

  modport master (
    output tick, btn_mode, btn_up, btn_down, btn_alarm,
    input  mode, field_sel, step_up, step_down, run_en, sec_clr, blink, alarm_armed
  );

  modport slave (
    input  tick, btn_mode, btn_up, btn_down, btn_alarm,
    output mode, field_sel, step_up, step_down, run_en, sec_clr, blink, alarm_armed
  );
endinterface

// File: rtl/time_set_controller.sv
// Front-panel sequencer for the alarm clock digit counters.
// Purpose: turns debounced button levels into one-hot field selects and
// single-cycle up/down steps, pauses the time chain while time is edited,
// clears seconds on leaving time edit, auto-repeats held up/down buttons,
// blinks the edited field, times out idle edits and arms/disarms the alarm.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : time_set_if.slave
//            in  : tick (2 Hz enable), btn_mode, btn_up, btn_down, btn_alarm
//            out : mode[2:0], field_sel[3:0], step_up, step_down, run_en,
//                  sec_clr, blink, alarm_armed (all registered)
module time_set_controller #(
  parameter int TIMEOUT_TICKS = 20,
  parameter int REPEAT_DELAY  = 2,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       reset,
  time_set_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_MIN  = 3'd1,
    SET_HOUR = 3'd2,
    SET_AMIN = 3'd3,
    SET_AHR  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       btn_q;          // {alarm, down, up, mode} delayed 1 clk
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       field_q, field_d;
  logic             step_up_q, step_up_d;
  logic             step_down_q, step_down_d;
  logic             run_en_q, run_en_d;
  logic             sec_clr_q, sec_clr_d;
  logic             blink_q, blink_d;
  logic             armed_q, armed_d;

  logic [3:0] btn_now;
  logic [3:0] press;
  logic       edit;
  logic       up_only;
  logic       down_only;
  logic       rep_fire;
  logic       any_act;
  logic       timeout;
  logic       changed;
  logic       allow_step;

  function automatic state_e next_state(input state_e s);
    case (s)
      RUN:      return SET_MIN;
      SET_MIN:  return SET_HOUR;
      SET_HOUR: return SET_AMIN;
      SET_AMIN: return SET_AHR;
      default:  return RUN;
    endcase
  endfunction

  function automatic logic in_time_edit(input state_e s);
    return (s == SET_MIN) || (s == SET_HOUR);
  endfunction

  function automatic logic [3:0] field_of(input state_e s);
    case (s)
      SET_MIN:  return 4'b0001;
      SET_HOUR: return 4'b0010;
      SET_AMIN: return 4'b0100;
      SET_AHR:  return 4'b1000;
      default:  return 4'b0000;
    endcase
  endfunction

  assign btn_now = {bus.btn_alarm, bus.btn_down, bus.btn_up, bus.btn_mode};
  assign press   = btn_now & ~btn_q;

  always_comb begin
    edit      = (state_q != RUN);
    up_only   = bus.btn_up & ~bus.btn_down;
    down_only = bus.btn_down & ~bus.btn_up;

    // Repeat fires on the tick that brings the hold count to REPEAT_DELAY and
    // on every tick after that; a fresh press takes precedence over a repeat.
    rep_fire = edit && bus.tick && (up_only || down_only) &&
               !(press[1] || press[2]) &&
               (hold_q >= CNT_W'(REPEAT_DELAY - 1));

    any_act = (|press) || rep_fire;
    timeout = edit && bus.tick && !any_act &&
              (idle_q >= CNT_W'(TIMEOUT_TICKS - 1));

    state_d = state_q;
    if (press[0]) begin
      state_d = next_state(state_q);
    end else if (timeout) begin
      state_d = RUN;
    end
    changed = (state_d != state_q);

    hold_d = hold_q;
    if (!edit || changed || !(up_only || down_only) || press[1] || press[2]) begin
      hold_d = '0;
    end else if (bus.tick && (hold_q < CNT_W'(REPEAT_DELAY))) begin
      hold_d = hold_q + CNT_W'(1);
    end

    idle_d = idle_q;
    if (any_act || changed) begin
      idle_d = '0;
    end else if (edit && bus.tick) begin
      idle_d = idle_q + CNT_W'(1);
    end

    // A mode press moves to another field, so any step in that cycle is dropped.
    allow_step  = edit && !press[0];
    step_up_d   = allow_step && up_only   && (press[1] || rep_fire);
    step_down_d = allow_step && down_only && (press[2] || rep_fire);

    run_en_d  = !in_time_edit(state_d);
    sec_clr_d = in_time_edit(state_q) && !in_time_edit(state_d);
    field_d   = field_of(state_d);

    blink_d = blink_q;
    if (state_d == RUN) begin
      blink_d = 1'b0;
    end else if (changed) begin
      blink_d = 1'b1;
    end else if (bus.tick) begin
      blink_d = ~blink_q;
    end

    armed_d = armed_q ^ (press[3] && (state_q == RUN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      btn_q       <= '0;
      idle_q      <= '0;
      hold_q      <= '0;
      field_q     <= 4'b0000;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      run_en_q    <= 1'b1;
      sec_clr_q   <= 1'b0;
      blink_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_now;
      idle_q      <= idle_d;
      hold_q      <= hold_d;
      field_q     <= field_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
      run_en_q    <= run_en_d;
      sec_clr_q   <= sec_clr_d;
      blink_q     <= blink_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.mode        = state_q;
  assign bus.field_sel   = field_q;
  assign bus.step_up     = step_up_q;
  assign bus.step_down   = step_down_q;
  assign bus.run_en      = run_en_q;
  assign bus.sec_clr     = sec_clr_q;
  assign bus.blink       = blink_q;
  assign bus.alarm_armed = armed_q;

endmodule
